// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_use_imm,
  input  logic              id_use_pc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              hold,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   alu_in_a,
  output logic [XLEN-1:0]   alu_in_b,
  output logic [OP_W-1:0]   alu_op
);

  logic              valid_q;
  logic [XLEN-1:0]   pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [OP_W-1:0]   op_q;
  logic              use_imm_q, use_pc_q, reg_write_q, mem_read_q, mem_write_q;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
  logic              hazard;

  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_q)
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_q)
      fwd_rs1 = memwb_result;
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_q)
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_q)
      fwd_rs2 = memwb_result;
  end

  assign hazard = valid_q && mem_read_q && rd_q != '0 && id_valid &&
                  (rd_q == id_rs1 || rd_q == id_rs2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      op_q        <= '0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (hold) begin
      // Capture forwarded values now so they survive the producers retiring.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else if (hazard) begin
      valid_q <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      op_q        <= id_alu_op;
      use_imm_q   <= id_use_imm;
      use_pc_q    <= id_use_pc;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end
  end

  assign id_stall      = hazard;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;
  assign ex_store_data = fwd_rs2;
  assign alu_in_a      = use_pc_q  ? pc_q  : fwd_rs1;
  assign alu_in_b      = use_imm_q ? imm_q : fwd_rs2;
  assign alu_op        = op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with a slot-level reference model
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write;
  logic        flush, hold;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_store_data, alu_in_a, alu_in_b;
  logic [4:0]  ex_rd;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .hold(hold),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently occupying EX.
  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        ui, up, rw, mr, mw;
  } slot_t;

  slot_t m;

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
    return d;
  endfunction

  function automatic logic model_stall();
    return m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic model_clear();
    m.valid = 0; m.pc = 0; m.d1 = 0; m.d2 = 0; m.imm = 0;
    m.rs1 = 0; m.rs2 = 0; m.rd = 0; m.op = 0;
    m.ui = 0; m.up = 0; m.rw = 0; m.mr = 0; m.mw = 0;
  endtask

  task automatic tick();
    slot_t n;
    n = m;
    if (flush) n.valid = 0;
    else if (hold) begin
      n.d1 = fwd(m.rs1, m.d1);
      n.d2 = fwd(m.rs2, m.d2);
    end else if (model_stall()) n.valid = 0;
    else begin
      n.valid = id_valid; n.pc = id_pc; n.d1 = id_rs1_data; n.d2 = id_rs2_data;
      n.imm = id_imm; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.op = id_alu_op;
      n.ui = id_use_imm; n.up = id_use_pc; n.rw = id_reg_write;
      n.mr = id_mem_read; n.mw = id_mem_write;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0;
    id_use_imm = 0; id_use_pc = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    flush = 0; hold = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic [3:0] op,
                        input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_pc = 32'h100; id_rs1 = rs1; id_rs1_data = d1;
    id_rs2 = rs2; id_rs2_data = d2; id_rd = rd; id_alu_op = op;
    id_use_imm = 0; id_use_pc = 0; id_imm = 0;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle(); model_clear();
    #2;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
    checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL reset_op got %0h exp 0", alu_op); end
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", id_stall); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
    checks++; if (ex_pc !== 0 || alu_in_a !== 0 || alu_in_b !== 0) begin
      errors++; $display("FAIL reset_data got pc=%h a=%h b=%h exp 0", ex_pc, alu_in_a, alu_in_b); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    drive_idle();
    set_id(5'd1, 32'd15, 5'd2, 32'd10, 5'd7, 4'b0000, 1, 0, 0);
    tick();
    drive_idle(); #1;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", ex_valid); end
    checks++; if (alu_in_a !== 32'd15) begin errors++; $display("FAIL add_a got %0d exp 15", alu_in_a); end
    checks++; if (alu_in_b !== 32'd10) begin errors++; $display("FAIL add_b got %0d exp 10", alu_in_b); end
    checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL add_op got %0h exp 0", alu_op); end
  endtask

  task automatic test_forward();
    drive_idle();
    set_id(5'd3, 32'd1, 5'd4, 32'd2, 5'd8, 4'b0010, 1, 0, 0);
    tick();
    drive_idle();
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 25;
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 7;
    #1;
    checks++; if (alu_in_a !== 32'd25) begin errors++; $display("FAIL fwd_exmem got %0d exp 25", alu_in_a); end
    exmem_reg_write = 0; #1;
    checks++; if (alu_in_a !== 32'd7) begin errors++; $display("FAIL fwd_memwb got %0d exp 7", alu_in_a); end
    drive_idle();
    set_id(5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 4'b0000, 1, 0, 0);
    tick();
    drive_idle();
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 99;
    #1;
    checks++; if (alu_in_a !== 32'd0) begin errors++; $display("FAIL fwd_x0 got %0d exp 0", alu_in_a); end
    drive_idle(); tick();
  endtask

  task automatic test_load_use();
    drive_idle();
    set_id(5'd1, 32'd0, 5'd0, 32'd0, 5'd5, 4'b0000, 1, 1, 0);
    tick();
    set_id(5'd6, 32'd3, 5'd5, 32'd4, 5'd10, 4'b0001, 1, 0, 0);
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || id_stall !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got valid=%0b stall=%0b exp 0 0", ex_valid, id_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || alu_op !== 4'b0001) begin
      errors++; $display("FAIL lu_resume got valid=%0b op=%0h exp 1 1", ex_valid, alu_op); end
    drive_idle(); tick();
  endtask

  task automatic test_hold();
    drive_idle();
    set_id(5'd4, 32'd0, 5'd0, 32'd0, 5'd11, 4'b0011, 1, 0, 0);
    tick();
    drive_idle();
    id_valid = 1; id_rs1 = 9; hold = 1;
    memwb_rd = 4; memwb_reg_write = 1; memwb_result = 32'h1234;
    #1;
    checks++; if (alu_in_a !== 32'h1234) begin errors++; $display("FAIL hold_c1 got %h exp 1234", alu_in_a); end
    tick();
    memwb_rd = 6; #1;
    checks++; if (alu_in_a !== 32'h1234) begin errors++; $display("FAIL hold_c2 got %h exp 1234", alu_in_a); end
    tick();
    hold = 0; id_valid = 0; #1;
    checks++; if (alu_in_a !== 32'h1234 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL hold_release got a=%h v=%0b exp 1234 1", alu_in_a, ex_valid); end
    drive_idle(); tick();
  endtask

  task automatic test_flush_reset();
    drive_idle();
    set_id(5'd1, 32'd5, 5'd2, 32'd6, 5'd0, 4'b0000, 0, 0, 1);
    tick();
    flush = 1; hold = 1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
      errors++; $display("FAIL flush_hold got v=%0b mw=%0b exp 0 0", ex_valid, ex_mem_write); end
    flush = 0; hold = 0;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL reload got %0b exp 1", ex_valid); end
    #2 rst = 1;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
      errors++; $display("FAIL async_rst got v=%0b mw=%0b exp 0 0", ex_valid, ex_mem_write); end
    rst = 0; model_clear(); drive_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      id_valid = $urandom_range(0, 3) != 0;
      id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_alu_op = 4'($urandom_range(0, 6));
      id_use_imm = 1'($urandom); id_use_pc = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = $urandom_range(0, 2) == 0;
      id_mem_write = 1'($urandom);
      flush = $urandom_range(0, 9) == 0; hold = $urandom_range(0, 3) == 0;
      exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      #1;
      checks++; if (id_stall !== model_stall()) begin
        errors++; $display("FAIL rnd_stall[%0d] got %0b exp %0b", i, id_stall, model_stall()); end
      checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !==
                    {m.valid, m.valid & m.rw, m.valid & m.mr, m.valid & m.mw}) begin
        errors++; $display("FAIL rnd_ctrl[%0d] got %b exp %b", i,
          {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
          {m.valid, m.valid & m.rw, m.valid & m.mr, m.valid & m.mw}); end
      if (m.valid) begin
        checks++; if (alu_in_a !== (m.up ? m.pc : fwd(m.rs1, m.d1))) begin
          errors++; $display("FAIL rnd_a[%0d] got %h exp %h", i, alu_in_a, m.up ? m.pc : fwd(m.rs1, m.d1)); end
        checks++; if (alu_in_b !== (m.ui ? m.imm : fwd(m.rs2, m.d2))) begin
          errors++; $display("FAIL rnd_b[%0d] got %h exp %h", i, alu_in_b, m.ui ? m.imm : fwd(m.rs2, m.d2)); end
        checks++; if (ex_store_data !== fwd(m.rs2, m.d2)) begin
          errors++; $display("FAIL rnd_sd[%0d] got %h exp %h", i, ex_store_data, fwd(m.rs2, m.d2)); end
        checks++; if (alu_op !== m.op || ex_pc !== m.pc || ex_rd !== m.rd) begin
          errors++; $display("FAIL rnd_fields[%0d] got op=%h pc=%h rd=%0d exp op=%h pc=%h rd=%0d",
            i, alu_op, ex_pc, ex_rd, m.op, m.pc, m.rd); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_hold();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
